// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store initiator.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } state_e;

  localparam logic [31:0] MASK_B0 = 32'h000000FF;
  localparam logic [31:0] MASK_B1 = 32'h0000FF00;
  localparam logic [31:0] MASK_B2 = 32'h00FF0000;
  localparam logic [31:0] MASK_B3 = 32'hFF000000;

  // The reserved size reports 4 bytes; such requests never reach memory.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rv_config_pkg.sv
// Core-wide configuration shared by the RISC-V blocks.
// DATA_BITS is the byte-address width of the data memory.
package rv_config;
  localparam int DATA_BITS = 10;
endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: positions store data/enables across two words and
// extracts, sign- or zero-extends load data from a captured word pair.
module lsu_lane_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_st_off,
  input  logic [2:0]  i_st_nbytes,
  output logic [63:0] o_wide_data,
  output logic [7:0]  o_lanes,
  input  logic [63:0] i_qpair,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_nbytes,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_base;
  logic [31:0] w_low;
  logic [31:0] w_mask;
  logic        w_sign;

  always_comb begin
    o_wide_data = {32'h0, i_wdata} << {i_st_off, 3'b000};
    w_base      = (8'd1 << i_st_nbytes) - 8'd1;
    o_lanes     = w_base << i_st_off;
  end

  assign w_low = 32'(i_qpair >> {i_ld_off, 3'b000});

  always_comb begin
    w_mask = MASK_B0 | MASK_B1 | MASK_B2 | MASK_B3;
    w_sign = 1'b0;
    case (i_ld_nbytes)
      3'd1: begin
        w_mask = MASK_B0;
        w_sign = w_low[7];
      end
      3'd2: begin
        w_mask = MASK_B0 | MASK_B1;
        w_sign = w_low[15];
      end
      default: ;
    endcase
    o_rdata = (w_low & w_mask) | ((w_sign && !i_unsigned) ? ~w_mask : 32'h0);
  end

endmodule

// File: rtl/riscv_data_mem_initiator.sv
// Load/store initiator for the word-addressed data memory; word-crossing
// accesses are split into two consecutive word accesses.
module riscv_data_mem_initiator
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_BITS      = 32,
  parameter int WORD_ADDR_BITS = rv_config::DATA_BITS - 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [WORD_ADDR_BITS-1:0] mem_address,
  input  logic [31:0]               mem_q,
  output logic                      mem_wren,
  output logic [3:0]                mem_byteena,
  output logic [31:0]               mem_data
);

  localparam logic [ADDR_BITS:0] LIMIT = (ADDR_BITS+1)'(1) << (WORD_ADDR_BITS + 2);

  state_e                    r_state;
  logic                      r_req_ready;
  logic                      r_resp_valid;
  logic                      r_resp_err;
  logic [31:0]               r_resp_rdata;
  logic [WORD_ADDR_BITS-1:0] r_mem_address;
  logic                      r_mem_wren;
  logic [3:0]                r_mem_byteena;
  logic [31:0]               r_mem_data;
  logic                      r_write;
  logic                      r_unsigned;
  logic                      r_split;
  logic [1:0]                r_off;
  logic [2:0]                r_nbytes;
  logic [WORD_ADDR_BITS-1:0] r_word0;
  logic [31:0]               r_wide_hi;
  logic [3:0]                r_lanes_hi;
  logic [31:0]               r_q0;

  logic [2:0]                w_nbytes;
  logic [ADDR_BITS:0]        w_end;
  logic                      w_err;
  logic                      w_split;
  logic [WORD_ADDR_BITS-1:0] w_word0;
  logic [63:0]               w_wide;
  logic [7:0]                w_lanes;
  logic [63:0]               w_qpair;
  logic [31:0]               w_load;

  // End address is one bit wider so accesses near the top of the byte space cannot wrap.
  assign w_nbytes = size_nbytes(req_size);
  assign w_end    = {1'b0, req_addr} + (ADDR_BITS+1)'(w_nbytes);
  assign w_err    = (req_size == SIZE_RSVD) || (w_end > LIMIT);
  assign w_split  = ({1'b0, req_addr[1:0]} + w_nbytes) > 3'd4;
  assign w_word0  = req_addr[WORD_ADDR_BITS+1:2];
  assign w_qpair  = (r_state == ST_ACC1) ? {mem_q, r_q0} : {32'h0, mem_q};

  lsu_lane_align u_align (
    .i_wdata     (req_wdata),
    .i_st_off    (req_addr[1:0]),
    .i_st_nbytes (w_nbytes),
    .o_wide_data (w_wide),
    .o_lanes     (w_lanes),
    .i_qpair     (w_qpair),
    .i_ld_off    (r_off),
    .i_ld_nbytes (r_nbytes),
    .i_unsigned  (r_unsigned),
    .o_rdata     (w_load)
  );

  // Outputs are registered on entry to each state, so ACC0 values come from the live request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_mem_address <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_byteena <= 4'h0;
      r_mem_data    <= 32'h0;
      r_write       <= 1'b0;
      r_unsigned    <= 1'b0;
      r_split       <= 1'b0;
      r_off         <= 2'b00;
      r_nbytes      <= 3'd0;
      r_word0       <= '0;
      r_wide_hi     <= 32'h0;
      r_lanes_hi    <= 4'h0;
      r_q0          <= 32'h0;
    end else begin
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_mem_address <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_byteena <= 4'h0;
      r_mem_data    <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_unsigned  <= req_unsigned;
            r_split     <= w_split;
            r_off       <= req_addr[1:0];
            r_nbytes    <= w_nbytes;
            r_word0     <= w_word0;
            r_wide_hi   <= w_wide[63:32];
            r_lanes_hi  <= w_lanes[7:4];
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state       <= ST_ACC0;
              r_mem_address <= w_word0;
              r_mem_byteena <= w_lanes[3:0];
              r_mem_data    <= w_wide[31:0];
              r_mem_wren    <= req_write;
            end
          end
        end
        ST_ACC0: begin
          if (!r_write) r_q0 <= mem_q;
          if (r_split) begin
            r_state       <= ST_ACC1;
            r_mem_address <= r_word0 + 1'b1;
            r_mem_byteena <= r_lanes_hi;
            r_mem_data    <= r_wide_hi;
            r_mem_wren    <= r_write;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'h0 : w_load;
          end
        end
        ST_ACC1: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_write ? 32'h0 : w_load;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_address = r_mem_address;
  assign mem_wren    = r_mem_wren;
  assign mem_byteena = r_mem_byteena;
  assign mem_data    = r_mem_data;

endmodule

// File: tb/tb_riscv_data_mem_initiator.sv
// Bench for riscv_data_mem_initiator: byte-array reference model predicts every
// cycle of outputs; directed cases pin the model with literal values.
module tb_riscv_data_mem_initiator;

  localparam int    WAB       = 8;
  localparam longint MEM_BYTES = 64'd1 << (WAB + 2);

  typedef struct {
    logic           ready;
    logic           rv;
    logic           err;
    logic [31:0]    rdata;
    logic [WAB-1:0] addr;
    logic           wren;
    logic [3:0]     be;
    logic [31:0]    data;
  } expCycle_t;

  typedef struct {
    logic [WAB-1:0] addr;
    logic [3:0]     be;
    logic [31:0]    data;
    logic           wren;
  } access_t;

  logic           clock;
  logic           reset_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [1:0]     req_size;
  logic           req_unsigned;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic [WAB-1:0] mem_address;
  logic [31:0]    mem_q;
  logic           mem_wren;
  logic [3:0]     mem_byteena;
  logic [31:0]    mem_data;

  logic [31:0] tbMem    [0:(1<<WAB)-1];
  logic [7:0]  refBytes [0:MEM_BYTES-1];

  expCycle_t expq[$];
  access_t   accLog[$];
  int        nCompared;
  int        nMismatch;
  int        cycleCnt;
  int        acceptCycle;
  int        respCycle;
  logic [31:0] lastRdata;
  logic        lastErr;
  bit          checkEn;

  riscv_data_mem_initiator #(
    .ADDR_BITS      (32),
    .WORD_ADDR_BITS (WAB)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_q        (mem_q),
    .mem_wren     (mem_wren),
    .mem_byteena  (mem_byteena),
    .mem_data     (mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory: combinational read, byte-enabled synchronous write.
  assign mem_q = tbMem[mem_address];
  always @(posedge clock) begin
    if (mem_wren === 1'b1)
      for (int l = 0; l < 4; l++)
        if (mem_byteena[l]) tbMem[mem_address][8*l +: 8] <= mem_data[8*l +: 8];
  end

  function automatic expCycle_t idleExp();
    expCycle_t e;
    e.ready = 1'b1; e.rv = 1'b0; e.err = 1'b0; e.rdata = 32'h0;
    e.addr = '0; e.wren = 1'b0; e.be = 4'h0; e.data = 32'h0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Predicts the cycles after acceptance from byte-level rules and updates the byte model.
  task automatic modelRequest(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input bit abort, output int nCycles);
    expCycle_t      e;
    int             nb, off, pos, w, l, a;
    longint         endAddr;
    logic [31:0]    dat [2];
    logic [3:0]     be  [2];
    logic [31:0]    v, mask;
    logic [WAB-1:0] word0;
    nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endAddr = longint'({32'd0, addr}) + nb;
    e       = idleExp();
    e.ready = 1'b0;
    if (sz == 2'b11 || endAddr > MEM_BYTES) begin
      e.rv = 1'b1; e.err = 1'b1;
      expq.push_back(e);
      nCycles = 1;
      return;
    end
    off   = int'(addr % 4);
    word0 = addr[WAB+1:2];
    dat[0] = 32'h0; dat[1] = 32'h0; be[0] = 4'h0; be[1] = 4'h0;
    for (int j = 0; j < 4; j++) begin
      pos = off + j; w = pos / 4; l = pos % 4;
      dat[w][8*l +: 8] = wd[8*j +: 8];
      if (j < nb) be[w][l] = 1'b1;
    end
    e.addr = word0; e.wren = wr; e.be = be[0]; e.data = dat[0];
    expq.push_back(e);
    nCycles = 2;
    if (off + nb > 4) begin
      e.addr = word0 + 1'b1; e.be = be[1]; e.data = dat[1];
      expq.push_back(e);
      nCycles = 3;
    end
    v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = refBytes[int'(addr) + i];
    mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    e = idleExp();
    e.ready = 1'b0; e.rv = 1'b1; e.rdata = wr ? 32'h0 : v;
    expq.push_back(e);
    if (wr)
      for (int i = 0; i < nb; i++) begin
        a = int'(addr) + i;
        if (!abort || (a / 4) == int'(word0)) refBytes[a] = wd[8*i +: 8];
      end
  endtask

  // Every cycle the bench is checking, the DUT outputs must match the predicted cycle.
  always @(negedge clock) begin
    expCycle_t e;
    if (checkEn) begin
      cycleCnt++;
      if (expq.size() > 0) e = expq.pop_front();
      else e = idleExp();
      nCompared++;
      if (req_ready !== e.ready || resp_valid !== e.rv || resp_err !== e.err ||
          resp_rdata !== e.rdata || mem_address !== e.addr || mem_wren !== e.wren ||
          mem_byteena !== e.be || mem_data !== e.data) begin
        nMismatch++;
        $display("[TB] FAIL cycle%0d: got rdy=%b rv=%b err=%b rdata=%h addr=%h wren=%b be=%b data=%h, expected rdy=%b rv=%b err=%b rdata=%h addr=%h wren=%b be=%b data=%h",
                 cycleCnt, req_ready, resp_valid, resp_err, resp_rdata, mem_address, mem_wren,
                 mem_byteena, mem_data, e.ready, e.rv, e.err, e.rdata, e.addr, e.wren, e.be, e.data);
      end
      if (resp_valid === 1'b1) begin
        lastRdata = resp_rdata;
        lastErr   = resp_err;
        respCycle = cycleCnt;
      end
      if (mem_wren === 1'b1 || mem_byteena != 4'h0)
        accLog.push_back('{mem_address, mem_byteena, mem_data, mem_wren});
    end
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, input bit abort);
    int n;
    @(negedge clock);
    accLog.delete();
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    acceptCycle = cycleCnt;
    modelRequest(wr, sz, uns, addr, wd, abort, n);
    if (abort) begin
      @(posedge clock);
      #1;
      checkEn = 1'b0;
      expq.delete();
      reset_n = 1'b0;
      #1;
      checkOutput("abort_wren", {31'h0, mem_wren}, 32'h0);
      checkOutput("abort_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("abort_resp", {31'h0, resp_valid}, 32'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      checkEn = 1'b1;
    end else begin
      repeat (n) @(posedge clock);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [1:0]  sz;
    logic [31:0] addr;
    nCompared = 0; nMismatch = 0; cycleCnt = 0; acceptCycle = 0; respCycle = 0;
    lastRdata = 32'h0; lastErr = 1'b0; checkEn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int w = 0; w < (1 << WAB); w++) begin
      tbMem[w] = $urandom;
      for (int l = 0; l < 4; l++) refBytes[4*w + l] = tbMem[w][8*l +: 8];
    end

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_rv", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_err", {31'h0, resp_err}, 32'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_wren", {31'h0, mem_wren}, 32'h0);
    checkOutput("rst_be", {28'h0, mem_byteena}, 32'h0);
    checkOutput("rst_addr", 32'(mem_address), 32'h0);
    checkOutput("rst_data", mem_data, 32'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    checkEn = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    checkOutput("sw_count", accLog.size(), 32'd1);
    if (accLog.size() == 1) begin
      checkOutput("sw_addr", 32'(accLog[0].addr), 32'd4);
      checkOutput("sw_be", {28'h0, accLog[0].be}, 32'hF);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_data", lastRdata, 32'hDEADBEEF);
    checkOutput("lw_latency", respCycle - acceptCycle, 32'd2);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 1'b0);
    checkOutput("sb_count", accLog.size(), 32'd1);
    if (accLog.size() == 1) begin
      checkOutput("sb_be", {28'h0, accLog[0].be}, 32'h8);
      checkOutput("sb_data", accLog[0].data, 32'hA5000000);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    checkOutput("lb_signed", lastRdata, 32'hFFFFFFA5);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    checkOutput("lbu", lastRdata, 32'h000000A5);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h80001234, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
    checkOutput("lh_hi", lastRdata, 32'hFFFF8000);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
    checkOutput("lh_lo", lastRdata, 32'h00001234);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0E, 32'h11223344, 1'b0);
    checkOutput("split_count", accLog.size(), 32'd2);
    checkOutput("split_latency", respCycle - acceptCycle, 32'd3);
    if (accLog.size() == 2) begin
      checkOutput("split0_addr", 32'(accLog[0].addr), 32'd3);
      checkOutput("split0_be", {28'h0, accLog[0].be}, 32'hC);
      checkOutput("split0_data", accLog[0].data, 32'h33440000);
      checkOutput("split1_addr", 32'(accLog[1].addr), 32'd4);
      checkOutput("split1_be", {28'h0, accLog[1].be}, 32'h3);
      checkOutput("split1_data", accLog[1].data, 32'h00001122);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 1'b0);
    checkOutput("split_load", lastRdata, 32'h11223344);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0);
    checkOutput("oor_err", {31'h0, lastErr}, 32'h1);
    checkOutput("oor_rdata", lastRdata, 32'h0);
    checkOutput("oor_latency", respCycle - acceptCycle, 32'd1);
    checkOutput("oor_noacc", accLog.size(), 32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 1'b0);
    checkOutput("rsvd_err", {31'h0, lastErr}, 32'h1);
    checkOutput("rsvd_rdata", lastRdata, 32'h0);
    checkOutput("rsvd_noacc", accLog.size(), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0);
    checkOutput("top_word_err", {31'h0, lastErr}, 32'h0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h24, 32'h05060708, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 1'b1);
    repeat (3) @(posedge clock);
    checkOutput("abort_word0", tbMem[8], 32'hF00D0304);
    checkOutput("abort_word1", tbMem[9], 32'h05060708);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    checkOutput("abort_readback", lastRdata, 32'hF00D0304);

    $display("[TB] random phase");
    for (int n = 0; n < 300; n++) begin
      rnd = $urandom_range(0, 15);
      sz  = (rnd < 5) ? 2'b00 : (rnd < 10) ? 2'b01 : (rnd < 15) ? 2'b10 : 2'b11;
      rnd = $urandom_range(0, 9);
      if (rnd < 8)       addr = $urandom_range(0, 63);
      else if (rnd == 8) addr = $urandom_range(1016, 1030);
      else               addr = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0);
    end
    repeat (2) @(posedge clock);
    for (int w = 0; w < (1 << WAB); w++)
      checkOutput($sformatf("mem_word%0d", w), tbMem[w],
                  {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/riscv_data_mem_initiator.md
Name: riscv_data_mem_initiator

Overview:
- Load/store initiator that drives the single-port word-addressed data memory from the core side.
- Accepts byte-addressed byte/half/word loads and stores over a valid/ready request channel.
- Translates each request into one or two word accesses with byte-enables. Misaligned accesses that cross a word boundary are split into two consecutive word accesses.
- Returns a one-cycle response pulse carrying the aligned, sign- or zero-extended load data.

Parameters:
- ADDR_BITS, 32, width of the core byte address.
- WORD_ADDR_BITS, rv_config::DATA_BITS - 2, width of the memory word address; the memory holds 2**WORD_ADDR_BITS words.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_BITS  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse, issued for loads and stores.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was out of range or used reserved size; qualified by resp_valid.
- mem_address  out  WORD_ADDR_BITS  word address to memory.
- mem_q  in  32  read data from memory; combinational from mem_address.
- mem_wren  out  1  memory write enable.
- mem_byteena  out  4  memory byte enables.
- mem_data  out  32  memory write data, lane-aligned.

Behaviour:
- Async reset (reset_n low): state IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
  - All capture registers cleared.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, size, write, unsigned and wdata.
  - Compute nbytes (1/2/4), off = addr[1:0], split = (off + nbytes > 4), and err.
  - err is set when size = 11, or when any byte of the access is at or above 2**(WORD_ADDR_BITS+2).
  - Next state is RESP if err, else ACC0.
- Lane alignment:
  - wide_data = 64-bit {0, wdata} << (8*off).
  - lanes = 8-bit ((1<<nbytes)-1) << off.
  - Word0 uses lanes[3:0] / wide_data[31:0]; word1 uses lanes[7:4] / wide_data[63:32].
- ACC0:
  - mem_address = addr[WORD_ADDR_BITS+1:2].
  - mem_byteena = lanes[3:0]; mem_data = wide_data[31:0]; mem_wren = write.
  - For loads, mem_q is captured into q0 at the clock edge.
  - Next state is ACC1 if split, else RESP.
- ACC1:
  - mem_address = word0 + 1.
  - mem_byteena = lanes[7:4]; mem_data = wide_data[63:32]; mem_wren = write.
  - For loads, q1 is captured.
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err = err.
  - Load: resp_rdata = ({q1,q0} >> 8*off)[nbytes*8-1:0], sign- or zero-extended to 32 bits.
  - Store or error: resp_rdata = 0.
  - Next state: IDLE.
- Outside ACC0/ACC1: mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
- Latency from accepting edge to resp_valid: 2 cycles (aligned), 3 cycles (split), 1 cycle (error).
- Throughput: one request per 3 or 4 cycles. There is no response backpressure; the consumer must take the pulse.
- An error request never asserts mem_wren or issues a memory access.
- Reset during ACC1 of a split store: word0 is already written, word1 is not, and there is no response. This partial write is accepted behaviour.
- mem_address uses WORD_ADDR_BITS-bit arithmetic. Wrap past the top of memory cannot occur because such a request is flagged err in IDLE.

Decomposition:
- Package riscv_lsu_pkg contains:
  - the size enum (SIZE_B, SIZE_H, SIZE_W);
  - the state enum;
  - the mask constants 32'h000000FF, 32'h0000FF00, 32'h00FF0000 and 32'hFF000000.
- Sub-module lsu_lane_align is purely combinational:
  - store path: wdata, off and nbytes in; wide_data and lanes out;
  - load path: {q1,q0}, off, nbytes and unsigned in; the 32-bit extended result out.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word from 0x10:
  - store: ACC0 drives mem_address=4, byteena=1111;
  - load: rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Store byte 0xA5 to 0x13:
  - byteena=1000, mem_data=0xA5000000, single access.
  - Then a signed byte load from 0x13 returns 0xFFFFFFA5; an unsigned byte load returns 0x000000A5.
- Memory word 4 = 0x80001234:
  - signed half load from 0x12 returns 0xFFFF8000;
  - signed half load from 0x10 returns 0x00001234.
- Store word 0x11223344 to 0x0E (split):
  - ACC0: address 3, byteena 1100, data 0x33440000;
  - ACC1: address 4, byteena 0011, data 0x00001122;
  - resp at 3 cycles. Reading it back as a word from 0x0E returns 0x11223344.
- Out-of-range or reserved size:
  - a load at byte address 2**(WORD_ADDR_BITS+2) gives resp_err=1 and rdata=0 one cycle after accept, with mem_wren never high;
  - a request with size=11 gives the same result.
- reset_n low during ACC1 of a split store:
  - mem_wren drops immediately, state returns to IDLE, no resp_valid;
  - word0 holds the new bytes and word1 is unchanged.
